// File: rtl/poly_horner_op_pkg.sv
// Shared types for the Horner polynomial evaluator.
package poly_horner_op_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } state_t;

  // Operation select for the shared add/multiply unit
  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } op_sel_t;

endpackage

// File: rtl/poly_horner_op_coef_rf.sv
// Coefficient register file: one synchronous write port, one asynchronous read port.
module poly_coef_rf #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DEGREE = 7
) (
  input  logic                                  ck,
  input  logic                                  rst,
  input  logic                                  we,
  input  logic [$clog2(MAX_DEGREE+1)-1:0]       wr_addr,
  input  logic [WIDTH-1:0]                      wr_data,
  input  logic [$clog2(MAX_DEGREE+1)-1:0]       rd_addr,
  output logic [WIDTH-1:0]                      rd_data
);

  localparam int unsigned DEG_W = $clog2(MAX_DEGREE + 1);
  localparam int unsigned DEPTH = MAX_DEGREE + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage: cleared on reset; addresses beyond MAX_DEGREE match no entry and are dropped
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (wr_addr == DEG_W'(i)) mem[i] <= wr_data;
    end
  end

  // Asynchronous read mux
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (rd_addr == DEG_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/poly_horner_op.sv
// Horner-method polynomial evaluator on one shared add/multiply unit.
module poly_horner_op
  import poly_horner_op_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DEGREE = 7,
  parameter int unsigned DEG_W      = $clog2(MAX_DEGREE + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             coef_we,
  input  logic [DEG_W-1:0] coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  input  logic [WIDTH-1:0] x,
  input  logic [DEG_W-1:0] degree,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  state_t           state, state_nxt;
  op_sel_t          op;
  logic [WIDTH-1:0] acc, x_reg;
  logic [DEG_W-1:0] idx, d_sel, rd_addr;
  logic [WIDTH-1:0] coef_rd;
  logic             accept, rf_we, deg_in_range;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] unit_res;
  logic             unit_ovf;

  poly_coef_rf #(
    .WIDTH      (WIDTH),
    .MAX_DEGREE (MAX_DEGREE)
  ) u_coef_rf (
    .ck      (ck),
    .rst     (rst),
    .we      (rf_we),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_addr (rd_addr),
    .rd_data (coef_rd)
  );

  // Clamp requested degree to MAX_DEGREE
  always_comb begin
    deg_in_range = 1'b0;
    for (int unsigned i = 0; i <= MAX_DEGREE; i++)
      if (degree == DEG_W'(i)) deg_in_range = 1'b1;
    d_sel = deg_in_range ? degree : DEG_W'(MAX_DEGREE);
  end

  // Control decode: accept/write gating, read address and unit op select
  always_comb begin
    accept  = (state == IDLE) && start;
    rf_we   = (state == IDLE) && coef_we && !start;
    rd_addr = (state == IDLE) ? d_sel : idx;
    op      = (state == MUL) ? OP_MUL : OP_ADD;
  end

  // Shared add/multiply unit with overflow/carry detect
  always_comb begin
    prod     = '0;
    sum      = '0;
    unit_res = '0;
    unit_ovf = 1'b0;
    case (op)
      OP_MUL: begin
        prod     = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_reg};
        unit_res = prod[WIDTH-1:0];
        unit_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        sum      = {1'b0, acc} + {1'b0, coef_rd};
        unit_res = sum[WIDTH-1:0];
        unit_ovf = sum[WIDTH];
      end
    endcase
  end

  // State register
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (d_sel != '0)) state_nxt = MUL;
      MUL:     state_nxt = ADD;
      ADD:     state_nxt = (idx == '0) ? IDLE : MUL;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; busy rises on the first MUL edge so it
  // spans the edge after acceptance up to done
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      x_reg  <= '0;
      idx    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x_reg <= x;
            acc   <= coef_rd;
            idx   <= d_sel;
            ovf   <= 1'b0;
            if (d_sel == '0) begin
              result <= coef_rd;
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc  <= unit_res;
          ovf  <= ovf | unit_ovf;
          idx  <= idx - DEG_W'(1);
          busy <= 1'b1;
        end
        ADD: begin
          ovf <= ovf | unit_ovf;
          if (idx == '0) begin
            result <= unit_res;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            acc <= unit_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_op.sv
// Directed self-checking bench for poly_horner_op.
module tb_poly_horner_op;

  logic        ck = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] x;
  logic [2:0]  degree;
  logic        start;
  logic        busy, done, ovf;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  poly_horner_op #(
    .WIDTH      (16),
    .MAX_DEGREE (7)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .x         (x),
    .degree    (degree),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 ck = ~ck;

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    @(negedge ck);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge ck);
    coef_we = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the accepting edge
  task automatic launch(input logic [15:0] xv, input logic [2:0] dv);
    @(negedge ck);
    x = xv; degree = dv; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
  endtask

  // lat = edges after the accepting edge at which done appeared (-1 if never)
  task automatic wait_done(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(posedge ck); #1; end
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    x = '0; degree = '0; start = 1'b0;
    #12;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
    checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    @(negedge ck); rst = 1'b1;
  endtask

  task automatic test_quadratic;
    int lat, bc;
    write_coef(3'd2, 16'd2); write_coef(3'd1, 16'd3); write_coef(3'd0, 16'd5);
    launch(16'd4, 3'd2);
    wait_done(lat, bc);
    checks++; if (lat != 4)          begin errors++; $display("FAIL quad_latency got %0d exp 4", lat); end
    checks++; if (bc != 3)           begin errors++; $display("FAIL quad_busy_cycles got %0d exp 3", bc); end
    checks++; if (result !== 16'd49) begin errors++; $display("FAIL quad_result got %0d exp 49", result); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL quad_ovf got %b exp 0", ovf); end
    @(posedge ck); #1;
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL quad_done_pulse got %b exp 0", done); end
    checks++; if (result !== 16'd49) begin errors++; $display("FAIL quad_result_hold got %0d exp 49", result); end
  endtask

  task automatic test_degree_zero;
    int lat, bc;
    write_coef(3'd0, 16'h1234);
    launch(16'hFFFF, 3'd0);
    wait_done(lat, bc);
    // degree-0 result registers on the accepting edge itself
    checks++; if (lat != 0)            begin errors++; $display("FAIL deg0_latency got %0d exp 0", lat); end
    checks++; if (bc != 0)             begin errors++; $display("FAIL deg0_busy got %0d exp 0", bc); end
    checks++; if (result !== 16'h1234) begin errors++; $display("FAIL deg0_result got %h exp 1234", result); end
  endtask

  task automatic test_mul_overflow;
    int lat, bc;
    write_coef(3'd1, 16'h0100); write_coef(3'd0, 16'h0000);
    launch(16'h0100, 3'd1);
    wait_done(lat, bc);
    checks++; if (lat != 2)            begin errors++; $display("FAIL mulovf_latency got %0d exp 2", lat); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mulovf_result got %h exp 0000", result); end
    checks++; if (ovf !== 1'b1)        begin errors++; $display("FAIL mulovf_ovf got %b exp 1", ovf); end
    write_coef(3'd1, 16'd1);
    checks++; if (ovf !== 1'b1)        begin errors++; $display("FAIL mulovf_sticky got %b exp 1", ovf); end
    launch(16'd2, 3'd1);
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL mulovf_clear_on_start got %b exp 0", ovf); end
    wait_done(lat, bc);
    checks++; if (result !== 16'd2)    begin errors++; $display("FAIL mulovf_next_result got %0d exp 2", result); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL mulovf_next_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_add_carry;
    int lat, bc;
    write_coef(3'd1, 16'd1); write_coef(3'd0, 16'd1);
    launch(16'hFFFF, 3'd1);
    wait_done(lat, bc);
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL carry_result got %h exp 0000", result); end
    checks++; if (ovf !== 1'b1)        begin errors++; $display("FAIL carry_ovf got %b exp 1", ovf); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    write_coef(3'd2, 16'd2); write_coef(3'd1, 16'd3); write_coef(3'd0, 16'd5);
    launch(16'd4, 3'd2);
    wait_done(lat, bc);
    // start held during the done cycle is accepted at the next edge
    x = 16'd1; degree = 3'd2; start = 1'b1;
    @(posedge ck); #1; start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat != 4)          begin errors++; $display("FAIL b2b_latency got %0d exp 4", lat); end
    checks++; if (result !== 16'd10) begin errors++; $display("FAIL b2b_result got %0d exp 10", result); end
  endtask

  task automatic test_busy_filtering;
    int ndone;
    ndone = 0;
    launch(16'd4, 3'd2);
    @(negedge ck);
    start = 1'b1; x = 16'd7; degree = 3'd1;
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd99;
    @(negedge ck);
    @(negedge ck);
    start = 1'b0; coef_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge ck); #1;
      if (done) begin
        ndone++;
        checks++; if (result !== 16'd49) begin errors++; $display("FAIL filt_result got %0d exp 49", result); end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL filt_done_count got %0d exp 1", ndone); end
    launch(16'd3, 3'd0);
    checks++; if (result !== 16'd5) begin errors++; $display("FAIL filt_coef0 got %0d exp 5", result); end
  endtask

  task automatic test_reset_mid_run;
    int ndone, lat, bc;
    ndone = 0;
    write_coef(3'd3, 16'd1);
    launch(16'd3, 3'd3);
    @(posedge ck); #2;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL rstmid_result got %h exp 0000", result); end
    @(negedge ck); rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge ck); #1;
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", ndone); end
    launch(16'd9, 3'd0);
    wait_done(lat, bc);
    checks++; if (lat != 0)         begin errors++; $display("FAIL rstmid_deg0_done got %0d exp 0", lat); end
    checks++; if (result !== 16'h0) begin errors++; $display("FAIL rstmid_coef_cleared got %h exp 0000", result); end
  endtask

  initial begin
    test_reset;
    test_quadratic;
    test_degree_zero;
    test_mul_overflow;
    test_add_carry;
    test_back_to_back;
    test_busy_filtering;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
